// File: rtl/service_protocol_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : service_protocol_decoder                                     |
// | Description : Pops a service packet word by word from a packet source,     |
// |               decodes the two header words, forwards each payload word to  |
// |               a data sink, checks the packet checksum and reports the      |
// |               outcome with a one-cycle ok/err pulse.                       |
// |                                                                            |
// | Packet layout (16-bit words):                                              |
// |   word1 = {addr[7:0], size[15:8]}                                          |
// |   word2 = {size[7:0], cmdCode[7:0]}                                        |
// |   payload words (size of them), CRC word, sequence number word             |
// | CRC = modulo-2^16 sum of word1, word2 and all payload words.               |
// |                                                                            |
// | Ports:                                                                     |
// |   clk, nRst         clock / synchronous active-low reset                   |
// |   packet_*          pop handshake towards the packet source                |
// |   data_*            push handshake towards the payload sink                |
// |   enable_i          decoder run enable                                     |
// |   addr_o, size_o,   decoded header fields                                  |
// |   cmd_code_o                                                               |
// |   num_o             decoded packet sequence number                         |
// |   busy_o            high while a packet is in progress                     |
// |   packet_ok_o/err_o one-cycle end-of-packet result pulses                  |
// |                                                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module service_protocol_decoder #(
  parameter logic [15:0] MAX_SIZE = 16'hFFFF
) (
  input  logic        clk,
  input  logic        nRst,
  output logic        packet_request_o,
  input  logic [15:0] packet_data_i,
  input  logic        packet_done_i,
  output logic        data_request_o,
  output logic [15:0] data_data_o,
  input  logic        data_done_i,
  input  logic        enable_i,
  output logic [7:0]  addr_o,
  output logic [15:0] size_o,
  output logic [7:0]  cmd_code_o,
  output logic [15:0] num_o,
  output logic        busy_o,
  output logic        packet_ok_o,
  output logic        packet_err_o
);

  typedef enum logic [3:0] {
    WAIT     = 4'd0,
    HEAD1_LR = 4'd1,
    HEAD1_LW = 4'd2,
    HEAD2_LR = 4'd3,
    HEAD2_LW = 4'd4,
    DATA_LR  = 4'd5,
    DATA_LW  = 4'd6,
    DATA_SR  = 4'd7,
    DATA_SW  = 4'd8,
    CRC_LR   = 4'd9,
    CRC_LW   = 4'd10,
    NUM_LR   = 4'd11,
    NUM_LW   = 4'd12,
    IDLE     = 4'd13
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] size_q, size_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] num_q, num_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] count_q, count_d;
  logic [15:0] payload_q, payload_d;
  logic        crc_ok_q, crc_ok_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic [15:0] head_size;

  // Full size as it will be once word2 is captured: high byte came with word1.
  assign head_size = {size_q[15:8], packet_data_i[15:8]};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    cmd_d     = cmd_q;
    num_d     = num_q;
    crc_d     = crc_q;
    count_d   = count_q;
    payload_d = payload_q;
    crc_ok_d  = crc_ok_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;

    if (!enable_i) begin
      // Dropping enable abandons the packet silently.
      state_d = WAIT;
    end else begin
      case (state_q)
        WAIT: begin
          state_d = HEAD1_LR;
          crc_d   = '0;
        end
        HEAD1_LR: state_d = HEAD1_LW;
        HEAD1_LW: begin
          if (packet_done_i) begin
            addr_d       = packet_data_i[15:8];
            size_d[15:8] = packet_data_i[7:0];
            crc_d        = crc_q + packet_data_i;
            state_d      = HEAD2_LR;
          end
        end
        HEAD2_LR: state_d = HEAD2_LW;
        HEAD2_LW: begin
          if (packet_done_i) begin
            size_d  = head_size;
            cmd_d   = packet_data_i[7:0];
            crc_d   = crc_q + packet_data_i;
            count_d = head_size;
            // Zero-extended so the compare stays meaningful at MAX_SIZE=16'hFFFF.
            if ({1'b0, head_size} > {1'b0, MAX_SIZE}) begin
              state_d = IDLE;
              err_d   = 1'b1;
            end else if (head_size == 16'd0) begin
              state_d = CRC_LR;
            end else begin
              state_d = DATA_LR;
            end
          end
        end
        DATA_LR: state_d = DATA_LW;
        DATA_LW: begin
          if (packet_done_i) begin
            payload_d = packet_data_i;
            crc_d     = crc_q + packet_data_i;
            count_d   = count_q - 16'd1;
            state_d   = DATA_SR;
          end
        end
        DATA_SR: state_d = DATA_SW;
        DATA_SW: begin
          if (data_done_i) begin
            state_d = (count_q == 16'd0) ? CRC_LR : DATA_LR;
          end
        end
        CRC_LR: state_d = CRC_LW;
        CRC_LW: begin
          if (packet_done_i) begin
            crc_ok_d = (packet_data_i == crc_q);
            state_d  = NUM_LR;
          end
        end
        NUM_LR: state_d = NUM_LW;
        NUM_LW: begin
          if (packet_done_i) begin
            num_d   = packet_data_i;
            ok_d    = crc_ok_q;
            err_d   = ~crc_ok_q;
            state_d = IDLE;
          end
        end
        IDLE:    state_d = IDLE;
        default: state_d = WAIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q   <= WAIT;
      addr_q    <= '0;
      size_q    <= '0;
      cmd_q     <= '0;
      num_q     <= '0;
      crc_q     <= '0;
      count_q   <= '0;
      payload_q <= '0;
      crc_ok_q  <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      cmd_q     <= cmd_d;
      num_q     <= num_d;
      crc_q     <= crc_d;
      count_q   <= count_d;
      payload_q <= payload_d;
      crc_ok_q  <= crc_ok_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
    end
  end

  // Request strobes are pure functions of the state, so each lasts exactly
  // the single cycle spent in the corresponding request state.
  assign packet_request_o = (state_q == HEAD1_LR) || (state_q == HEAD2_LR) ||
                            (state_q == DATA_LR)  || (state_q == CRC_LR)   ||
                            (state_q == NUM_LR);
  assign data_request_o   = (state_q == DATA_SR);
  assign data_data_o      = payload_q;
  assign busy_o           = (state_q != WAIT) && (state_q != IDLE);
  assign addr_o           = addr_q;
  assign size_o           = size_q;
  assign cmd_code_o       = cmd_q;
  assign num_o            = num_q;
  assign packet_ok_o      = ok_q;
  assign packet_err_o     = err_q;

endmodule
`default_nettype wire
